// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage MIPS pipeline: control-word bit
// positions, ID/EX hazard FSM states and register-file constants.
package pipe_pkg;

   localparam int CTRL_W = 9;

   // Control word layout {regwrite, memread, memwrite, memtoreg, alusrc, regdst, branch, aluop[1:0]}
   localparam int CTRL_REGWRITE = 8;
   localparam int CTRL_MEMREAD  = 7;
   localparam int CTRL_MEMWRITE = 6;
   localparam int CTRL_MEMTOREG = 5;
   localparam int CTRL_ALUSRC   = 4;
   localparam int CTRL_REGDST   = 3;
   localparam int CTRL_BRANCH   = 2;
   localparam int CTRL_ALUOP    = 0;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic {ST_RUN, ST_STALL} state_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: ID-side fields in, registered EX-side copies out.
interface id_ex_stage_if
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 9
);
   logic              id_valid;
   logic [REG_W-1:0]  id_rs;
   logic [REG_W-1:0]  id_rt;
   logic [REG_W-1:0]  id_rd;
   logic [31:0]       id_readda1;
   logic [31:0]       id_readda2;
   logic [31:0]       id_imm;
   logic [CTRL_W-1:0] id_ctrl;

   logic              ex_valid;
   logic [REG_W-1:0]  ex_rs;
   logic [REG_W-1:0]  ex_rt;
   logic [REG_W-1:0]  ex_rd;
   logic [31:0]       ex_readda1;
   logic [31:0]       ex_readda2;
   logic [31:0]       ex_imm;
   logic [CTRL_W-1:0] ex_ctrl;

   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_readda1, id_readda2, id_imm, id_ctrl,
      input  ex_valid, ex_rs, ex_rt, ex_rd, ex_readda1, ex_readda2, ex_imm, ex_ctrl
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_readda1, id_readda2, id_imm, id_ctrl,
      output ex_valid, ex_rs, ex_rt, ex_rd, ex_readda1, ex_readda2, ex_imm, ex_ctrl
   );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds a
// source operand of the instruction in ID. Register zero never stalls.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic             ex_valid,
   input  logic             ex_memread,
   input  logic             id_valid,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   output logic             lu
);

   assign lu = ex_valid & ex_memread & id_valid & (ex_rt != REG_ZERO) &
               ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and global hold.
// Optional stall counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage #(
   parameter int CTRL_W = pipe_pkg::CTRL_W,
   parameter int CNT_W  = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic hold,
   id_ex_stage_if.slave bus,
   output logic pc_write,
   output logic ifid_write
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);
   import pipe_pkg::*;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   state_t            state_p1;
   logic              vld_p1;
   logic [REG_W-1:0]  rs_p1;
   logic [REG_W-1:0]  rt_p1;
   logic [REG_W-1:0]  rd_p1;
   logic [31:0]       rda1_p1;
   logic [31:0]       rda2_p1;
   logic [31:0]       imm_p1;
   logic [CTRL_W-1:0] ctrl_p1;

   logic lu;
   logic stall_now;

   hazard_detect u_hazard (
      .ex_valid   (vld_p1),
      .ex_memread (ctrl_p1[CTRL_MEMREAD]),
      .id_valid   (bus.id_valid),
      .ex_rt      (rt_p1),
      .id_rs      (bus.id_rs),
      .id_rt      (bus.id_rt),
      .lu         (lu)
   );

   // In STALL the EX slot already holds the bubble, so a hazard can only bite in RUN.
   assign stall_now  = lu & (state_p1 == ST_RUN);
   assign pc_write   = ~stall_now & ~hold;
   assign ifid_write = ~stall_now & ~hold;

   // ID -> EX stage boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p1 <= ST_RUN;
         vld_p1   <= 1'b0;
         ctrl_p1  <= '0;
         rs_p1    <= '0;
         rt_p1    <= '0;
         rd_p1    <= '0;
         rda1_p1  <= '0;
         rda2_p1  <= '0;
         imm_p1   <= '0;
      end else if (flush || !hold) begin
         rs_p1   <= bus.id_rs;
         rt_p1   <= bus.id_rt;
         rd_p1   <= bus.id_rd;
         rda1_p1 <= bus.id_readda1;
         rda2_p1 <= bus.id_readda2;
         imm_p1  <= bus.id_imm;
         if (flush) begin
            state_p1 <= ST_RUN;
            vld_p1   <= 1'b0;
            ctrl_p1  <= '0;
         end else if (stall_now) begin
            state_p1 <= ST_STALL;
            vld_p1   <= 1'b0;
            ctrl_p1  <= '0;
         end else begin
            state_p1 <= ST_RUN;
            vld_p1   <= bus.id_valid;
            ctrl_p1  <= bus.id_ctrl;
         end
      end
   end

   assign bus.ex_valid   = vld_p1;
   assign bus.ex_rs      = rs_p1;
   assign bus.ex_rt      = rt_p1;
   assign bus.ex_rd      = rd_p1;
   assign bus.ex_readda1 = rda1_p1;
   assign bus.ex_readda2 = rda2_p1;
   assign bus.ex_imm     = imm_p1;
   assign bus.ex_ctrl    = ctrl_p1;

`ifdef ID_EX_STALL_CNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [CNT_W-1:0] cnt_p1;

   // Counts only real load-use bubbles; flush and hold edges never count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p1 <= '0;
      end else if (!flush && !hold && stall_now) begin
         cnt_p1 <= sat_inc(cnt_p1);
      end
   end

   assign stall_cnt = cnt_p1;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the stage.
module tb_id_ex_stage;
   import pipe_pkg::*;

   localparam logic [8:0] C_ADD = 9'h10A; // regwrite, regdst, aluop=10
   localparam logic [8:0] C_LW  = 9'h1B0; // regwrite, memread, memtoreg, alusrc

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   logic hold;
   logic pc_write;
   logic ifid_write;
`ifdef ID_EX_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   id_ex_stage_if #(.CTRL_W(CTRL_W)) bus ();

   id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .hold       (hold),
      .bus        (bus.slave),
      .pc_write   (pc_write),
      .ifid_write (ifid_write)
`ifdef ID_EX_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: what EX should hold, whether the last edge inserted a bubble, bubble count.
   bit          m_valid;
   bit          m_bubbled;
   logic [4:0]  m_rs, m_rt, m_rd;
   logic [31:0] m_r1, m_r2, m_imm;
   logic [8:0]  m_ctrl;
   int unsigned m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_bubbled = 0; m_cnt = 0;
      m_rs = '0; m_rt = '0; m_rd = '0;
      m_r1 = '0; m_r2 = '0; m_imm = '0; m_ctrl = '0;
   endtask

   // A load in EX writing a nonzero register that ID reads must cost one bubble,
   // unless that bubble was just inserted on the previous edge.
   function automatic bit model_stall();
      bit hit;
      hit = m_valid && m_ctrl[CTRL_MEMREAD] && bus.id_valid && (m_rt != 5'd0) &&
            ((m_rt == bus.id_rs) || (m_rt == bus.id_rt));
      return hit && !m_bubbled;
   endfunction

   task automatic model_edge();
      bit st;
      st = model_stall();
      if (flush) begin
         m_valid = 0; m_ctrl = '0; m_bubbled = 0;
      end else if (hold) begin
         // everything keeps its value
      end else if (st) begin
         m_valid = 0; m_ctrl = '0; m_bubbled = 1;
         if (m_cnt != 65535) m_cnt++;
      end else begin
         m_valid = bus.id_valid; m_ctrl = bus.id_ctrl; m_bubbled = 0;
         m_rs = bus.id_rs; m_rt = bus.id_rt; m_rd = bus.id_rd;
         m_r1 = bus.id_readda1; m_r2 = bus.id_readda2; m_imm = bus.id_imm;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, " ex_valid"}, 32'(bus.ex_valid), 32'(m_valid));
      check({tag, " ex_ctrl"}, 32'(bus.ex_ctrl), 32'(m_ctrl));
      if (m_valid) begin
         check({tag, " ex_rs"}, 32'(bus.ex_rs), 32'(m_rs));
         check({tag, " ex_rt"}, 32'(bus.ex_rt), 32'(m_rt));
         check({tag, " ex_rd"}, 32'(bus.ex_rd), 32'(m_rd));
         check({tag, " ex_readda1"}, bus.ex_readda1, m_r1);
         check({tag, " ex_readda2"}, bus.ex_readda2, m_r2);
         check({tag, " ex_imm"}, bus.ex_imm, m_imm);
      end
`ifdef ID_EX_STALL_CNT_EN
      check({tag, " stall_cnt"}, 32'(stall_cnt), m_cnt);
`endif
   endtask

   // Called just after a falling edge: drive ID, check the combinational
   // enables, cross the rising edge, then check EX on the next falling edge.
   task automatic step(input string tag, input bit v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [8:0] c, input bit fl, input bit hd);
      bit exp_en;
      bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
      bus.id_readda1 = a; bus.id_readda2 = b; bus.id_imm = im; bus.id_ctrl = c;
      flush = fl; hold = hd;
      #1;
      exp_en = !model_stall() && !hd;
      check({tag, " pc_write"}, 32'(pc_write), 32'(exp_en));
      check({tag, " ifid_write"}, 32'(ifid_write), 32'(exp_en));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, " ex_valid"}, 32'(bus.ex_valid), 32'd0);
      check({tag, " ex_ctrl"}, 32'(bus.ex_ctrl), 32'd0);
      check({tag, " ex_rt"}, 32'(bus.ex_rt), 32'd0);
      check({tag, " ex_readda1"}, bus.ex_readda1, 32'd0);
      check({tag, " ex_imm"}, bus.ex_imm, 32'd0);
      check({tag, " pc_write"}, 32'(pc_write), 32'd1);
      check({tag, " ifid_write"}, 32'(ifid_write), 32'd1);
`ifdef ID_EX_STALL_CNT_EN
      check({tag, " stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
      bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
      bus.id_readda1 = '0; bus.id_readda2 = '0; bus.id_imm = '0; bus.id_ctrl = '0;
      model_reset();
      #1;
      reset_checks("reset");
      @(negedge clk);
      rst_n = 1'b1;

      step("capture", 1, 5'd1, 5'd3, 5'd2, 32'd9, 32'd5, 32'h0000_0010, C_ADD, 0, 0);

      // Load-use: one bubble, then the stalled add enters EX.
      step("lu_lw",    1, 5'd1, 5'd5, 5'd0, 32'd11, 32'd12, 32'd4, C_LW, 0, 0);
      step("lu_stall", 1, 5'd5, 5'd6, 5'd7, 32'd21, 32'd22, 32'd0, C_ADD, 0, 0);
      step("lu_after", 1, 5'd5, 5'd6, 5'd7, 32'd21, 32'd22, 32'd0, C_ADD, 0, 0);
      step("lu_next",  1, 5'd2, 5'd3, 5'd4, 32'd31, 32'd32, 32'd0, C_ADD, 0, 0);

      // Register zero never stalls.
      step("zero_lw",  1, 5'd1, 5'd0, 5'd0, 32'd1, 32'd2, 32'd8, C_LW, 0, 0);
      step("zero_add", 1, 5'd0, 5'd0, 5'd9, 32'd3, 32'd4, 32'd0, C_ADD, 0, 0);

      // Flush coinciding with a load-use hazard wins; no bubble is counted.
      step("fl_lw",    1, 5'd1, 5'd7, 5'd0, 32'd5, 32'd6, 32'd12, C_LW, 0, 0);
      step("fl_both",  1, 5'd7, 5'd2, 5'd3, 32'd7, 32'd8, 32'd0, C_ADD, 1, 0);
      step("fl_after", 1, 5'd7, 5'd2, 5'd3, 32'd7, 32'd8, 32'd0, C_ADD, 0, 0);

      // Hold for three edges while the stall bubble sits in EX.
      step("hd_lw",    1, 5'd1, 5'd9, 5'd0, 32'd1, 32'd1, 32'd16, C_LW, 0, 0);
      step("hd_stall", 1, 5'd4, 5'd9, 5'd8, 32'hAA, 32'hBB, 32'd0, C_ADD, 0, 0);
      for (int i = 0; i < 3; i++)
         step("hd_hold", 1, 5'd4, 5'd9, 5'd8, 32'hAA, 32'hBB, 32'd0, C_ADD, 0, 1);
      step("hd_release", 1, 5'd4, 5'd9, 5'd8, 32'hAA, 32'hBB, 32'd0, C_ADD, 0, 0);

      // Asynchronous reset in the middle of a stall.
      step("rs_lw",    1, 5'd1, 5'd4, 5'd0, 32'd2, 32'd3, 32'd20, C_LW, 0, 0);
      step("rs_stall", 1, 5'd4, 5'd1, 5'd6, 32'hC0, 32'hC1, 32'd0, C_ADD, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      reset_checks("reset_mid");
      @(negedge clk);
      rst_n = 1'b1;
      step("rs_after", 1, 5'd4, 5'd1, 5'd6, 32'hC0, 32'hC1, 32'd0, C_ADD, 0, 0);

      // Random traffic over a small register set so hazards are frequent.
      for (int i = 0; i < 300; i++) begin
         logic [8:0] c;
         c = 9'($urandom);
         c[CTRL_MEMREAD] = ($urandom_range(0, 1) == 1);
         step("rand", ($urandom_range(0, 9) != 0),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
              $urandom, $urandom, $urandom, c,
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the five-stage MIPS core. Sits directly downstream of the register file: captures the two read operands, immediate, register specifiers and decoded control word from decode, and presents them to execute one cycle later. Detects a load in EX whose destination matches a source in ID, inserts exactly one bubble, and freezes PC and IF/ID. Also honours branch flush and an external global hold.

## Interface
- `CTRL_W`, default 9: width of the decoded control word.
- `CNT_W`, default 16: stall counter width (only with the counter feature).
- `clk` in 1: pipeline clock, all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: branch/jump redirect; squash the instruction entering EX.
- `hold` in 1: global freeze (e.g. memory wait); all state holds.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt`, `id_rd` in 5 each: register specifiers from decode.
- `id_readda1`, `id_readda2` in 32 each: register file read data.
- `id_imm` in 32: sign-extended immediate.
- `id_ctrl` in CTRL_W: control bundle {regwrite, memread, memwrite, memtoreg, alusrc, regdst, branch, aluop[1:0]}.
- `ex_valid`, `ex_rs`, `ex_rt`, `ex_rd`, `ex_readda1`, `ex_readda2`, `ex_imm`, `ex_ctrl` out: registered copies to execute.
- `pc_write`, `ifid_write` out 1: enables for PC and IF/ID registers.
- `stall_cnt` out CNT_W: load-use stall count (only with `ID_EX_STALL_CNT_EN`).

## Operation
- Load-use condition `lu` = `ex_valid & ex_ctrl.memread & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt)`. Register 0 never causes a stall.
- FSM, two states:
  - RUN: if `lu` and no `flush`/`hold`, go STALL; else stay.
  - STALL: go RUN on next non-hold edge.
- Per-edge priority, highest first:
  1. `flush`: `ex_valid`=0, `ex_ctrl`=0, FSM to RUN. Data fields are don't-care and are loaded from ID.
  2. `hold`: every register, FSM state and counter keeps its value.
  3. `lu` in RUN: bubble, with `ex_valid`=0 and `ex_ctrl`=0. The counter increments.
  4. Otherwise: capture all ID fields.
- `pc_write` = `ifid_write` = `!(lu & state==RUN) & !hold`. `flush` does not gate them, because the redirect must load the PC.
- In STALL the EX stage holds a bubble, so `lu` is false and the stalled instruction is captured. A load-use hazard therefore costs exactly one cycle.
- Register file writes on negedge, so no WB-to-ID bypass is required here.

## Timing
- Registered path latency is 1 cycle, from ID inputs at edge N to EX outputs after edge N.
- `pc_write`/`ifid_write` are combinational from current ID inputs and EX registers. They settle within the same cycle.
- Reset (async assert, sync to clock domain by upstream deassert):
  - all `ex_*` outputs are 0;
  - state is RUN;
  - `stall_cnt` is 0;
  - `pc_write`/`ifid_write` are 1.
- Reset mid-stall returns to RUN immediately. The pending bubble is lost, which is harmless because EX is invalid.
- `stall_cnt` saturates at all-ones and does not wrap.

## Configuration
- `ID_EX_STALL_CNT_EN` defined: `stall_cnt` port and counter exist. The counter increments once per inserted load-use bubble, excluding flush and hold cycles.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Shared package `pipe_pkg`:
  - control-bit index constants (`CTRL_REGWRITE` .. `CTRL_ALUOP`), plus `CTRL_W`;
  - FSM state enum `{ST_RUN, ST_STALL}`;
  - register-zero constant.
- Sub-module `hazard_detect`: purely combinational `lu` computation. It is reused by the forwarding-unit bench.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle -> all `ex_*`=0 immediately, `pc_write`=1, `stall_cnt`=0.
- Plain capture: ID add rs=1, rt=3, rd=2, readda1=9, readda2=5 -> next cycle `ex_rs`=1, `ex_readda1`=9, `ex_readda2`=5, `ex_valid`=1, no stall.
- Load-use:
  - Setup: lw with rt=5 in EX, add with rs=5 in ID.
  - Stall cycle: `pc_write`=0 and `ifid_write`=0 for exactly one cycle, with `ex_valid`=0 and `ex_ctrl`=0.
  - Next cycle: add captured, `stall_cnt`=1.
- Zero register: lw with rt=0 in EX, ID rs=0 -> no stall, `pc_write` stays 1.
- Flush vs stall: load-use condition with `flush`=1 on the same edge -> bubble, state RUN, `pc_write`=0 that cycle, `stall_cnt` unchanged.
- Hold: `hold`=1 for 3 cycles during STALL -> outputs, state and counter frozen. After release, STALL→RUN and the instruction is captured on the first free edge.
